// File: rtl/ram_arb_if.sv
// Bus bundle between the two requesters (core, program loader), the arbiter and a synchronous RAM.
interface ram_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_req, l_we, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we, busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, ram_rdata,
    output c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
           ram_addr, ram_wdata, ram_we, busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, ram_rdata,
    input  c_gnt, c_rvalid, c_rdata, l_gnt, l_rvalid, l_rdata,
           ram_addr, ram_wdata, ram_we, busy
  );
endinterface

// File: rtl/ram_arb.sv
// Two-requester single-port RAM arbiter: core vs program loader, bounded bursts,
// alternating tie-break and read returns routed by a registered issuer tag.
module ram_arb #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic      clk,
  input  logic      reset,
  ram_arb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CORE, LOAD} state_t;

  localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

  state_t        r_state, w_next, w_other;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          r_last_core, w_last_core_next;
  logic          r_rd_pend, r_rd_core;
  logic          w_own_core, w_own_load, w_own_req, w_own_we, w_oth_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  assign w_own_core = (r_state == CORE);
  assign w_own_load = (r_state == LOAD);
  assign w_own_req  = (w_own_core & bus.c_req) | (w_own_load & bus.l_req);
  assign w_own_we   = w_own_core ? bus.c_we : bus.l_we;
  assign w_oth_req  = w_own_core ? bus.l_req : bus.c_req;
  assign w_other    = w_own_core ? LOAD : CORE;
  assign w_addr     = w_own_core ? bus.c_addr  : bus.l_addr;
  assign w_wdata    = w_own_core ? bus.c_wdata : bus.l_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_core <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_core   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_last_core <= w_last_core_next;
      r_rd_pend   <= w_own_req & ~w_own_we;
      r_rd_core   <= w_own_core;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_cnt_next       = r_cnt;
    w_last_core_next = r_last_core;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        // On a tie the requester that did not own the port last goes first.
        if (bus.c_req && (!bus.l_req || !r_last_core)) w_next = CORE;
        else if (bus.l_req)                             w_next = LOAD;
      end
      CORE, LOAD: begin
        if (!w_own_req) begin
          w_next           = w_oth_req ? w_other : IDLE;
          w_cnt_next       = '0;
          w_last_core_next = w_own_core;
        end else if (r_cnt == LAST) begin
          // Burst exhausted: hand over if anyone waits, else restart the burst.
          w_cnt_next = '0;
          if (w_oth_req) begin
            w_next           = w_other;
            w_last_core_next = w_own_core;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  assign bus.c_gnt     = w_own_core;
  assign bus.l_gnt     = w_own_load;
  assign bus.busy      = w_own_core | w_own_load;
  assign bus.ram_we    = w_own_req & w_own_we;
  assign bus.ram_addr  = w_own_req ? w_addr  : {AW{1'b0}};
  assign bus.ram_wdata = w_own_req ? w_wdata : {DW{1'b0}};

  assign bus.c_rvalid  = r_rd_pend &  r_rd_core;
  assign bus.l_rvalid  = r_rd_pend & ~r_rd_core;
  assign bus.c_rdata   = bus.c_rvalid ? bus.ram_rdata : {DW{1'b0}};
  assign bus.l_rdata   = bus.l_rvalid ? bus.ram_rdata : {DW{1'b0}};
endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a behavioural synchronous RAM and a bounded random traffic phase.
module tb_ram_arb;
  localparam int MB = 4;

  logic clk, reset;
  logic [7:0] mem [256];
  int n_cmp, n_err;

  ram_arb_if #(.AW(8), .DW(8)) bus();

  ram_arb #(.AW(8), .DW(8), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    bus.c_req = 1; bus.l_req = 1;
    step; step;
    n_cmp++;
    if ({bus.c_gnt, bus.l_gnt, bus.busy, bus.ram_we, bus.c_rvalid, bus.l_rvalid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl got gnt=%b%b busy=%b we=%b rv=%b%b want all 0", bus.c_gnt, bus.l_gnt,
               bus.busy, bus.ram_we, bus.c_rvalid, bus.l_rvalid);
    end
    n_cmp++;
    if ({bus.ram_addr, bus.ram_wdata, bus.c_rdata, bus.l_rdata} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h wd=%h crd=%h lrd=%h want 0", bus.ram_addr,
               bus.ram_wdata, bus.c_rdata, bus.l_rdata);
    end
  endtask

  task automatic test_tie;
    bus.c_we = 1; bus.c_addr = 8'h01; bus.c_wdata = 8'h11;
    bus.l_we = 1; bus.l_addr = 8'h02; bus.l_wdata = 8'h22;
    reset = 0;
    for (int i = 0; i < MB; i++) begin
      step;
      n_cmp++;
      if ({bus.c_gnt, bus.l_gnt, bus.busy, bus.ram_we, bus.ram_addr} !== {4'b1011, 8'h01}) begin
        n_err++;
        $display("FAIL tie_core_%0d got gnt=%b%b busy=%b we=%b addr=%h want 1011/01", i, bus.c_gnt,
                 bus.l_gnt, bus.busy, bus.ram_we, bus.ram_addr);
      end
    end
    step;
    n_cmp++;
    if ({bus.c_gnt, bus.l_gnt, bus.ram_addr, bus.ram_wdata} !== {2'b01, 8'h02, 8'h22}) begin
      n_err++;
      $display("FAIL tie_handover got gnt=%b%b addr=%h wd=%h want 01/02/22", bus.c_gnt, bus.l_gnt,
               bus.ram_addr, bus.ram_wdata);
    end
    idle_reqs;
    step;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL tie_idle got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_core_read;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
    step;
    n_cmp++;
    if ({bus.c_gnt, bus.ram_we, bus.c_rvalid, bus.ram_addr} !== {3'b100, 8'h10}) begin
      n_err++;
      $display("FAIL rd_issue got gnt=%b we=%b rv=%b addr=%h want 1/0/0/10", bus.c_gnt, bus.ram_we,
               bus.c_rvalid, bus.ram_addr);
    end
    step;
    n_cmp++;
    if ({bus.c_rvalid, bus.l_rvalid, bus.c_rdata, bus.l_rdata} !== {2'b10, 8'hA5, 8'h00}) begin
      n_err++;
      $display("FAIL rd_return got rv=%b%b crd=%h lrd=%h want 10/A5/00", bus.c_rvalid,
               bus.l_rvalid, bus.c_rdata, bus.l_rdata);
    end
    idle_reqs;
    step;
    n_cmp++;
    if ({bus.c_rvalid, bus.c_rdata, bus.busy} !== 10'h0) begin
      n_err++;
      $display("FAIL rd_quiet got rv=%b crd=%h busy=%b want 0", bus.c_rvalid, bus.c_rdata, bus.busy);
    end
  endtask

  task automatic test_loader_write;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 8'h20; bus.l_wdata = 8'h3C;
    step;
    n_cmp++;
    if ({bus.c_gnt, bus.l_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {3'b011, 8'h20, 8'h3C}) begin
      n_err++;
      $display("FAIL ld_write got gnt=%b%b we=%b addr=%h wd=%h want 01/1/20/3C", bus.c_gnt,
               bus.l_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    for (int i = 1; i <= 6; i++) begin
      bus.l_addr = 8'(8'h20 + i); bus.l_wdata = 8'(8'h3C + i);
      step;
      n_cmp++;
      if ({bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.ram_addr} !== {3'b100, 8'(8'h20 + i)}) begin
        n_err++;
        $display("FAIL ld_burst_%0d got gnt=%b rv=%b%b addr=%h want 1/00/%h", i, bus.l_gnt,
                 bus.c_rvalid, bus.l_rvalid, bus.ram_addr, 8'(8'h20 + i));
      end
    end
    idle_reqs;
    step;
  endtask

  task automatic test_read_handoff;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h11;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 8'h30; bus.l_wdata = 8'h77;
    for (int i = 0; i < MB; i++) begin
      step;
      n_cmp++;
      if ({bus.c_gnt, bus.l_gnt} !== 2'b10) begin
        n_err++;
        $display("FAIL ho_core_%0d got gnt=%b%b want 10", i, bus.c_gnt, bus.l_gnt);
      end
    end
    step;
    n_cmp++;
    if ({bus.l_gnt, bus.c_rvalid, bus.l_rvalid, bus.c_rdata} !== {3'b110, 8'h5A}) begin
      n_err++;
      $display("FAIL ho_return got lgnt=%b rv=%b%b crd=%h want 1/10/5A", bus.l_gnt,
               bus.c_rvalid, bus.l_rvalid, bus.c_rdata);
    end
    idle_reqs;
    step;
    n_cmp++;
    if ({bus.c_rvalid, bus.l_rvalid, bus.busy} !== 3'b000) begin
      n_err++;
      $display("FAIL ho_quiet got rv=%b%b busy=%b want 000", bus.c_rvalid, bus.l_rvalid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_read;
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h05; bus.c_wdata = 8'h09;
    step;
    idle_reqs;
    step;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
    step;
    n_cmp++;
    if (bus.c_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre got cgnt=%b want 1", bus.c_gnt);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({bus.c_gnt, bus.l_gnt, bus.busy, bus.ram_we, bus.c_rvalid, bus.l_rvalid, bus.ram_addr,
         bus.c_rdata} !== 22'h0) begin
      n_err++;
      $display("FAIL mid_reset got gnt=%b%b busy=%b we=%b rv=%b%b addr=%h crd=%h want 0", bus.c_gnt,
               bus.l_gnt, bus.busy, bus.ram_we, bus.c_rvalid, bus.l_rvalid, bus.ram_addr, bus.c_rdata);
    end
    step;
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 8'h40; bus.l_wdata = 8'h01;
    reset = 0;
    step;
    n_cmp++;
    if ({bus.c_gnt, bus.l_gnt, bus.c_rvalid, bus.l_rvalid} !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_after got gnt=%b%b rv=%b%b want 10/00", bus.c_gnt, bus.l_gnt,
               bus.c_rvalid, bus.l_rvalid);
    end
    idle_reqs;
    step;
  endtask

  task automatic test_random;
    int cw, lw, shown;
    cw = 0; lw = 0; shown = 0;
    for (int i = 0; i < 10000; i++) begin
      step;
      cw = (bus.c_req && !bus.c_gnt) ? cw + 1 : 0;
      lw = (bus.l_req && !bus.l_gnt) ? lw + 1 : 0;
      n_cmp++;
      if ((bus.c_gnt && bus.l_gnt) || (bus.ram_we && !(bus.c_gnt || bus.l_gnt)) ||
          cw > MB + 1 || lw > MB + 1) begin
        n_err++;
        if (shown < 10)
          $display("FAIL rand_%0d got gnt=%b%b we=%b cwait=%0d lwait=%0d want no overlap, wait<=%0d",
                   i, bus.c_gnt, bus.l_gnt, bus.ram_we, cw, lw, MB + 1);
        shown++;
      end
      if (!bus.c_req) begin
        if ($urandom_range(1, 0) == 1) begin
          bus.c_req = 1; bus.c_we = 1'($urandom); bus.c_addr = 8'($urandom); bus.c_wdata = 8'($urandom);
        end
      end else if (bus.c_gnt) begin
        bus.c_we = 1'($urandom); bus.c_addr = 8'($urandom); bus.c_wdata = 8'($urandom);
        if ($urandom_range(3, 0) == 0) bus.c_req = 0;
      end
      if (!bus.l_req) begin
        if ($urandom_range(1, 0) == 1) begin
          bus.l_req = 1; bus.l_we = 1'($urandom); bus.l_addr = 8'($urandom); bus.l_wdata = 8'($urandom);
        end
      end else if (bus.l_gnt) begin
        bus.l_we = 1'($urandom); bus.l_addr = 8'($urandom); bus.l_wdata = 8'($urandom);
        if ($urandom_range(3, 0) == 0) bus.l_req = 0;
      end
    end
    idle_reqs;
    step; step;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h5A;
    reset = 1;
    idle_reqs;
    test_reset;
    test_tie;
    test_core_read;
    test_loader_write;
    test_read_handoff;
    test_reset_mid_read;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter AW, default 8, RAM address width in bits.
REQ-002 Parameter DW, default 8, RAM data width in bits.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive accesses per grant while the other requester waits; legal range 1..15.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 c_req  in  1  core requests RAM access; held high with c_we, c_addr and c_wdata stable until granted.
REQ-007 c_we  in  1  core access is a write (1) or a read (0).
REQ-008 c_addr  in  AW  core access address.
REQ-009 c_wdata  in  DW  core write data.
REQ-010 c_gnt  out  1  core owns the RAM port this cycle.
REQ-011 c_rvalid  out  1  core read data valid this cycle.
REQ-012 c_rdata  out  DW  core read data.
REQ-013 l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  program-loader request set; same rules as the core set.
REQ-014 l_gnt, l_rvalid, l_rdata  out  1/1/DW  program-loader grant and read return.
REQ-015 ram_addr  out  AW  RAM address.
REQ-016 ram_wdata  out  DW  RAM write data.
REQ-017 ram_we  out  1  RAM write enable.
REQ-018 ram_rdata  in  DW  RAM read data; synchronous RAM, valid one cycle after the read address is presented.
REQ-019 busy  out  1  high whenever either grant is high.

Function
REQ-020 The FSM SHALL have three states: IDLE, CORE, LOAD; c_gnt = (state==CORE) and l_gnt = (state==LOAD), both decoded combinationally from state.
REQ-021 An access SHALL occur in every cycle in which the owner's req is high; ram_addr, ram_wdata and ram_we SHALL be muxed combinationally from the owner, with ram_we = owner_req & owner_we.
REQ-022 In IDLE, or when the owner's req is low, ram_we SHALL be 0 and ram_addr/ram_wdata SHALL be 0.
REQ-023 IDLE: if only one req is high, go to that requester's state; if both are high, go to the requester that is not last_owner; if none, stay in IDLE.
REQ-024 Grant latency SHALL be exactly one cycle from IDLE: a req first sampled high in IDLE yields gnt in the following cycle.
REQ-025 In CORE or LOAD, a burst counter SHALL count accesses; it SHALL be cleared on every state entry.
REQ-026 In CORE or LOAD, if the owner drops req, go to the other state when the other req is high, else go to IDLE.
REQ-027 In CORE or LOAD, when the counter reaches MAX_BURST and the other req is high, go to the other state; if the other req is low, stay in the current state and clear the counter.
REQ-028 last_owner SHALL update to the owner on every exit from CORE or LOAD.
REQ-029 A read access SHALL assert the issuing requester's rvalid exactly one cycle later, for one cycle, with rdata = ram_rdata; the non-issuing requester's rvalid SHALL stay 0.
REQ-030 A read return SHALL be delivered to the issuer even if ownership changes in the cycle after the read; routing SHALL use a registered issuer tag, not the current grant.
REQ-031 c_rdata and l_rdata SHALL be 0 in any cycle their rvalid is 0.
REQ-032 Writes SHALL produce no rvalid.
REQ-033 The two grants SHALL never be high together.
REQ-034 ram_we SHALL never be high without a grant.

Reset
REQ-035 While reset is high: state = IDLE, burst counter = 0, last_owner = LOAD (core wins the first tie), read-pending flag = 0.
REQ-036 While reset is high, all outputs SHALL be 0; an in-flight read SHALL be discarded and no rvalid SHALL appear after reset is released.
REQ-037 The first arbitration decision after reset SHALL occur on the first rising edge at which reset is low.

Verification
REQ-038 Both req high from IDLE after reset -> c_gnt=1 next cycle; l_gnt=0 for the first 4 accesses; l_gnt=1 on the cycle after the 4th core access.
REQ-039 Core read at addr 0x10, RAM returns 0xA5 -> c_rvalid=1 and c_rdata=0xA5 exactly one cycle later; l_rvalid stays 0.
REQ-040 Loader writes 0x3C to 0x20 while c_req=0 -> ram_we=1, ram_addr=0x20, ram_wdata=0x3C in the granted cycle; 5+ back-to-back loader writes keep l_gnt continuously high.
REQ-041 Core read on its last burst cycle, loader granted next -> c_rvalid=1 (not l_rvalid) with that read's data in the cycle after the core read.
REQ-042 Reset asserted mid-read with c_gnt=1 -> all outputs 0 immediately; no rvalid after release; a subsequent tie grants the core first.
REQ-043 Random req/we traffic for 10k cycles -> grants never overlap, ram_we never high without a grant, and each requester waits at most MAX_BURST+1 cycles after raising req.
